// File: rtl/dmme_pkg.sv
// Shared types for the dmme dot-product engine.
// Mode encoding and control FSM states.
package dmme_pkg;

    typedef enum logic {
        DENDEN = 1'b0,
        SPADEN = 1'b1
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN1,
        DRAIN2,
        DONE
    } state_e;

endpackage

// File: rtl/dmme_lane_dot.sv
// One channel: sparse operand select, registered lane products,
// and the combinational lane sum feeding the accumulator.
module dmme_lane_dot
    import dmme_pkg::*;
#(
    parameter int LANES = 4,
    parameter int EW    = 16,
    parameter int AW    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  mode_e                 mode,
    input  logic [LANES*EW-1:0]   a,
    input  logic [LANES*EW-1:0]   b,
    input  logic [LANES-1:0]      mask,
    output logic [AW-1:0]         sum
);

    logic [EW-1:0]   a_sel  [LANES];
    logic [2*EW-1:0] prod_q [LANES];

    // In sparse mode B lane j pairs with the compressed A entry whose
    // index is the number of set mask bits below j.
    always_comb begin
        int k;
        k = 0;
        for (int j = 0; j < LANES; j++) begin
            a_sel[j] = '0;
            if (mode == DENDEN) begin
                a_sel[j] = a[j*EW +: EW];
            end else if (mask[j]) begin
                k = 0;
                for (int i = 0; i < j; i++) begin
                    k += int'(mask[i]);
                end
                a_sel[j] = a[k*EW +: EW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int j = 0; j < LANES; j++) begin
                prod_q[j] <= '0;
            end
        end else if (en && load) begin
            for (int j = 0; j < LANES; j++) begin
                prod_q[j] <= {{EW{1'b0}}, a_sel[j]}
                           * {{EW{1'b0}}, b[j*EW +: EW]};
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int j = 0; j < LANES; j++) begin
            sum = sum + AW'(prod_q[j]);
        end
    end

endmodule

// File: rtl/dmme_param.sv
// Multi-channel dense/sparse dot-product engine with burst control,
// a two-stage multiply/accumulate pipeline and a held result register.
module dmme_param
    import dmme_pkg::*;
#(
    parameter int CH    = 2,
    parameter int LANES = 4,
    parameter int EW    = 16,
    parameter int AW    = 32,
    parameter int LENW  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     start,
    input  logic                     mode,
    input  logic [LENW-1:0]          len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH*LANES*EW-1:0]   ain,
    input  logic [CH*LANES*EW-1:0]   bin,
    input  logic [CH*LANES-1:0]      maskin,
    output logic [CH*AW-1:0]         cout,
    output logic                     busy,
    output logic                     done
);

    state_e          state;
    state_e          nxt;
    mode_e           mode_q;
    logic [LENW-1:0] len_q;
    logic [LENW-1:0] cnt;
    logic            s1_valid;
    logic            accept;
    logic            last;
    logic            launch;
    logic [AW-1:0]   acc [CH];
    logic [AW-1:0]   sum [CH];

    assign in_ready = en && (state == RUN);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;
    assign last     = accept && (LENW'(cnt + 1'b1) == len_q);
    assign launch   = (state == IDLE) && start;

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start) nxt = (len == '0) ? DONE : RUN;
            RUN:     if (last) nxt = DRAIN1;
            DRAIN1:  nxt = DRAIN2;
            DRAIN2:  nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        dmme_lane_dot #(
            .LANES(LANES),
            .EW   (EW),
            .AW   (AW)
        ) u_dot (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .load (accept),
            .mode (mode_q),
            .a    (ain[c*LANES*EW +: LANES*EW]),
            .b    (bin[c*LANES*EW +: LANES*EW]),
            .mask (maskin[c*LANES +: LANES]),
            .sum  (sum[c])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            mode_q   <= DENDEN;
            len_q    <= '0;
            cnt      <= '0;
            s1_valid <= 1'b0;
            done     <= 1'b0;
            cout     <= '0;
            for (int c = 0; c < CH; c++) begin
                acc[c] <= '0;
            end
        end else if (en) begin
            state    <= nxt;
            s1_valid <= accept;
            done     <= (nxt == DONE);
            if (launch) begin
                mode_q <= mode_e'(mode);
                len_q  <= len;
                cnt    <= '0;
            end else if (accept) begin
                cnt <= cnt + 1'b1;
            end
            for (int c = 0; c < CH; c++) begin
                if (launch) begin
                    acc[c] <= '0;
                end else if (s1_valid) begin
                    acc[c] <= acc[c] + sum[c];
                end
            end
            // A zero-length burst reaches DONE before the cleared
            // accumulators are visible, so it reports zero directly.
            if (nxt == DONE) begin
                for (int c = 0; c < CH; c++) begin
                    cout[c*AW +: AW] <= (state == IDLE) ? '0 : acc[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmme_param.sv
// Directed bench for dmme_param; expected results are queued at stimulus
// time and checked by an independent monitor on each done pulse.
module tb_dmme_param;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         start;
    logic         mode;
    logic [7:0]   len;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ain;
    logic [127:0] bin;
    logic [7:0]   maskin;
    logic [63:0]  cout;
    logic         busy;
    logic         done;

    logic [63:0]  exp_q[$];
    int           checks   = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    dmme_param dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .start    (start),
        .mode     (mode),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ain      (ain),
        .bin      (bin),
        .maskin   (maskin),
        .cout     (cout),
        .busy     (busy),
        .done     (done)
    );

    function automatic logic [63:0] pk4(input logic [15:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: one comparison per rising edge of done.
    initial begin
        logic       done_d;
        logic [63:0] e;
        done_d = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1 && done_d !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=%h required=none",
                             cout);
                end else begin
                    e = exp_q.pop_front();
                    chk("cout", cout, e);
                end
            end
            done_d = done;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic start_burst(input logic m, input logic [7:0] l);
        start = 1'b1;
        mode  = m;
        len   = l;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [127:0] a, input logic [127:0] b,
                             input logic [7:0] m);
        int n;
        in_valid = 1'b1;
        ain      = a;
        bin      = b;
        maskin   = m;
        n        = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout actual=%0d required=<20", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done !== 1'b1 && lat < 50);
        if (done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=%0d required=<50", lat);
        end
    endtask

    initial begin
        int   lat;
        int   dcnt;
        logic seen;
        logic [127:0] all1;
        logic [127:0] all2;
        logic [127:0] allf;

        all1 = {2{pk4(1, 1, 1, 1)}};
        all2 = {2{pk4(2, 2, 2, 2)}};
        allf = {2{pk4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF)}};

        rst = 1'b0; en = 1'b1; start = 1'b0; mode = 1'b0; len = '0;
        in_valid = 1'b0; ain = '0; bin = '0; maskin = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_cout", cout, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Dense, len=1; mask is garbage and must be ignored.
        exp_q.push_back({32'd100, 32'd70});
        start_burst(1'b0, 8'd1);
        send_beat({pk4(1, 1, 1, 1), pk4(1, 2, 3, 4)},
                  {pk4(10, 20, 30, 40), pk4(5, 6, 7, 8)}, 8'hA5);
        wait_done(lat);
        chk("dense_latency", 64'(lat), 64'd3);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        @(posedge clk);
        #1;

        // Sparse, ch0 mask 0101 -> 42, ch1 mask 0 -> 0.
        exp_q.push_back({32'd0, 32'd42});
        start_burst(1'b1, 8'd1);
        send_beat({pk4(7, 7, 7, 7), pk4(3, 9, 0, 0)},
                  {pk4(5, 5, 5, 5), pk4(2, 100, 4, 100)}, 8'h05);
        wait_done(lat);
        @(posedge clk);
        #1;

        // Sparse, two beats: full mask and single top-lane mask.
        exp_q.push_back({32'd21, 32'd52});
        start_burst(1'b1, 8'd2);
        send_beat({pk4(7, 7, 7, 7), pk4(3, 9, 0, 0)},
                  {pk4(5, 5, 5, 5), pk4(2, 100, 4, 100)}, 8'h05);
        send_beat({pk4(7, 5, 5, 5), pk4(1, 2, 3, 4)},
                  {pk4(0, 0, 0, 3), pk4(1, 1, 1, 1)}, 8'h8F);
        wait_done(lat);
        @(posedge clk);
        #1;

        // len=3 with valid gaps; start during the burst is ignored.
        exp_q.push_back({32'd48, 32'd48});
        start_burst(1'b0, 8'd3);
        send_beat(all2, all2, 8'h00);
        start = 1'b1; mode = 1'b1; len = 8'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_beat(all2, all2, 8'h00);
        @(posedge clk);
        #1;
        send_beat(all2, all2, 8'h00);
        @(negedge clk);
        chk("in_ready_after_last", 64'(in_ready), 64'd0);
        wait_done(lat);
        @(posedge clk);
        #1;

        // Accumulator wrap.
        exp_q.push_back({32'hFFF00008, 32'hFFF00008});
        start_burst(1'b0, 8'd2);
        send_beat(allf, allf, 8'h00);
        send_beat(allf, allf, 8'h00);
        wait_done(lat);
        @(posedge clk);
        #1;

        // Reset in the middle of a burst.
        start_burst(1'b0, 8'd3);
        send_beat(all1, all1, 8'h00);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_rst_busy", 64'(busy), 64'd0);
        chk("midrun_rst_in_ready", 64'(in_ready), 64'd0);
        chk("midrun_rst_cout", cout, 64'd0);
        seen = done;
        repeat (5) begin
            @(negedge clk);
            seen = seen | done;
        end
        chk("midrun_rst_no_done", 64'(seen), 64'd0);
        @(posedge clk);
        #1;

        // en=0 for 3 cycles mid-RUN and again during DONE.
        exp_q.push_back({32'd1000100, 32'd80});
        start_burst(1'b0, 8'd2);
        send_beat({pk4(0, 0, 0, 10), pk4(1, 2, 3, 4)},
                  {pk4(0, 0, 0, 10), pk4(4, 3, 2, 1)}, 8'h00);
        en = 1'b0;
        @(negedge clk);
        chk("en0_in_ready", 64'(in_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        en = 1'b1;
        send_beat({pk4(1000, 0, 0, 0), pk4(3, 3, 3, 3)},
                  {pk4(1000, 0, 0, 0), pk4(5, 5, 5, 5)}, 8'h00);
        wait_done(lat);
        chk("en_run_latency", 64'(lat), 64'd3);
        en = 1'b0;
        dcnt = 1;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        chk("en0_cout_hold", cout, {32'd1000100, 32'd80});
        en = 1'b1;
        @(negedge clk);
        if (done === 1'b1) dcnt++;
        chk("done_stretched", 64'(dcnt), 64'd4);
        @(posedge clk);
        #1;

        // len=0, then a start presented during DONE is ignored.
        exp_q.push_back(64'd0);
        start_burst(1'b0, 8'd0);
        start = 1'b1; len = 8'd1;
        @(negedge clk);
        chk("len0_done", 64'(done), 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("start_in_done_ignored", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmme_param.md
DMME_PARAM -- requirements
Module: dmme_param

Interface
REQ-001 Parameter CH, default 2, number of independent dot-product channels.
REQ-002 Parameter LANES, default 4, elements per channel per beat.
REQ-003 Parameter EW, default 16, element width in bits, unsigned.
REQ-004 Parameter AW, default 32, accumulator and result width per channel.
REQ-005 Parameter LENW, default 8, width of the burst-length field.
REQ-006 The block SHALL use one clock and a synchronous, active-low reset, with the following ports.
REQ-007 clk  in  1  the single clock; all state updates on the rising edge.
REQ-008 rst  in  1  synchronous active-low reset.
REQ-009 en  in  1  global enable; 0 freezes all state.
REQ-010 start  in  1  burst request, sampled in IDLE only.
REQ-011 mode  in  1  0 = DENDEN (dense x dense), 1 = SPADEN (sparse x dense); latched on start.
REQ-012 len  in  LENW  beats in the burst; latched on start.
REQ-013 in_valid  in  1  ain/bin/maskin beat valid.
REQ-014 in_ready  out  1  block accepts a beat.
REQ-015 ain  in  CH*LANES*EW  A operands; channel c, lane l at bits [(c*LANES+l)*EW +: EW].
REQ-016 bin  in  CH*LANES*EW  B operands, same packing.
REQ-017 maskin  in  CH*LANES  per-channel sparsity mask of A, bit c*LANES+l.
REQ-018 cout  out  CH*AW  per-channel result; channel c at [c*AW +: AW].
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 done  out  1  result-valid pulse.

Function
REQ-021 FSM states: IDLE, RUN, DRAIN1, DRAIN2, DONE; all transitions occur only on edges where en=1.
REQ-022 IDLE: in_ready=0; on start=1, latch mode/len, clear all accumulators, go to RUN (len>0) or DONE (len=0).
REQ-023 RUN: in_ready=en; beat accepted on an edge with in_valid & in_ready; beat counter increments per accepted beat; the edge accepting beat len-1 moves the FSM to DRAIN1.
REQ-024 in_valid gaps in RUN SHALL stall without side effects; no beat is accepted outside RUN.
REQ-025 Pipeline stage 1 (registered): per channel, per lane, product of EW x EW -> 2*EW bits unsigned.
REQ-026 Pipeline stage 2: per channel, lane products summed and zero-extended to AW, added into the accumulator modulo 2^AW (wrap, no saturation).
REQ-027 DENDEN: product of lane l = a[l]*b[l]; maskin ignored.
REQ-028 SPADEN: A is compressed; with p = popcount(mask), a[k] for k<p pairs with b at the position of the k-th set mask bit (LSB first); a[k] for k>=p is ignored; mask=0 contributes 0.
REQ-029 DRAIN1 -> DRAIN2 -> DONE unconditionally, flushing the pipeline.
REQ-030 DONE: cout register loads the accumulators, done=1, next state IDLE; done is high in the cycle after the edge two edges after the one accepting the final beat.
REQ-031 cout SHALL hold its value until the next DONE or reset.
REQ-032 start, mode, len changes while busy=1 SHALL be ignored.
REQ-033 en=0: all registers hold (including done and pipeline), in_ready=0.
REQ-034 start in the same cycle as DONE SHALL be ignored; a new burst requires start in IDLE.

Reset
REQ-035 rst=0 on an edge, in any state including mid-burst: FSM->IDLE, accumulators, pipeline registers, beat counter and cout cleared to 0, done=0, busy=0, in_ready=0.
REQ-036 Reset SHALL take priority over en.

Structure
REQ-037 Package dmme_pkg SHALL hold the mode encoding (DENDEN=0, SPADEN=1) and the FSM state enumeration.
REQ-038 One sub-module dmme_lane_dot SHALL implement one channel's sparse operand selection, stage-1 product registers and lane sum; it is instantiated CH times.

Verification
REQ-039 Dense, len=1, ch0 a={1,2,3,4}, b={5,6,7,8} -> cout ch0 = 70, done one cycle, 3 edges after beat accept.
REQ-040 Sparse, mask=4'b0101, a={3,9,0,0}, b={2,100,4,100} -> 3*2+9*4 = 42; mask=0 -> 0.
REQ-041 len=3, in_valid toggled 1,0,1,0,1 with a=b=all 2 -> 48 per channel; in_ready low after the 3rd beat.
REQ-042 Wrap: AW=32, a=b=all 16'hFFFF, len=2 -> 2*4*0xFFFE0001 mod 2^32 = 0xFFF00008.
REQ-043 len=0 -> done in the second cycle after start, cout=0; rst=0 mid-RUN -> IDLE, cout=0, no done.
REQ-044 en=0 for 3 cycles mid-RUN and during DONE -> results unchanged vs. the en=1 run; done stretched by the frozen cycles.
